// File: rtl/id_issue_pkg.sv
// Shared constants and helpers for the decode/issue slice: register
// address width, scoreboard geometry and default datapath widths.
package id_issue_pkg;

    localparam int REG_AW      = 5;
    localparam int NREG        = 32;
    localparam int XLEN_DEF    = 32;
    localparam int PW_DEF      = 128;
    localparam int CNT_W_DEF   = 2;
    localparam int NSRC_DEF    = 2;
    localparam int NSTAGE_DEF  = 3;

    // Bypass port field widths (one dest tag and one data word per stage)
    localparam int BYP_DEST_W  = REG_AW;
    localparam int BYP_DATA_W  = XLEN_DEF;

    // A source port participates in hazard checks only when used and not r0
    function automatic logic src_active(input logic en, input logic [REG_AW-1:0] addr);
        return en && (addr != 5'd0);
    endfunction

    // Isolate the lowest set bit: lowest index wins, i.e. the youngest stage
    function automatic logic [NSTAGE_DEF-1:0] first_hit(input logic [NSTAGE_DEF-1:0] hit);
        return hit & (~hit + 3'd1);
    endfunction

endpackage

// File: rtl/id_scoreboard.sv
// Per-register pending-writeback counters for long-latency producers.
// Increments on issue of a long op, decrements on retire; a retire that
// finds its counter already at zero latches a sticky error flag.
module id_scoreboard
    import id_issue_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int NLOOK = NSRC_DEF + 1
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    inc_en,
    input  logic [REG_AW-1:0]       inc_addr,
    input  logic                    dec_en,
    input  logic [REG_AW-1:0]       dec_addr,
    input  logic [NLOOK*REG_AW-1:0] look_addr,
    output logic [NLOOK*CNT_W-1:0]  look_cnt,
    output logic                    err
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_r     [NREG];
    logic [CNT_W-1:0] cnt_nxt_s [NREG];
    logic [NREG-1:0]  inc_hit_s;
    logic [NREG-1:0]  dec_hit_s;
    logic             err_r;
    logic             err_nxt_s;
    logic             underflow_s;

    for (genvar i = 0; i < NREG; i++) begin : g_hit
        assign inc_hit_s[i] = inc_en && (inc_addr == REG_AW'(i));
        assign dec_hit_s[i] = dec_en && (dec_addr == REG_AW'(i));
    end

    for (genvar k = 0; k < NLOOK; k++) begin : g_look
        assign look_cnt[k*CNT_W +: CNT_W] = cnt_r[look_addr[k*REG_AW +: REG_AW]];
    end

    // Retire with nothing pending; a matching same-cycle issue cancels it out
    assign underflow_s = dec_en
                      && !(inc_en && (inc_addr == dec_addr))
                      && (cnt_r[dec_addr] == CNT_ZERO);

    // Next counter values: inc and dec on one register cancel, both saturate
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            cnt_nxt_s[i] = cnt_r[i];
            if (inc_hit_s[i] && !dec_hit_s[i] && (cnt_r[i] != CNT_MAX)) begin
                cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
            end else if (dec_hit_s[i] && !inc_hit_s[i] && (cnt_r[i] != CNT_ZERO)) begin
                cnt_nxt_s[i] = cnt_r[i] - CNT_ONE;
            end else begin
                cnt_nxt_s[i] = cnt_r[i];
            end
        end
        err_nxt_s = err_r | underflow_s;
    end

    // Counter and sticky error registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < NREG; i++) begin
                cnt_r[i] <= CNT_ZERO;
            end
            err_r <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
            end
            err_r <= err_nxt_s;
        end
    end

    assign err = err_r;

endmodule

// File: rtl/id_issue_unit.sv
// Decode/issue stage: one-entry holding register, operand resolution from
// bypass stages or the register file, and hazard detection against the
// bypass network and the long-latency scoreboard.
module id_issue_unit
    import id_issue_pkg::*;
#(
    parameter int NSRC   = NSRC_DEF,
    parameter int NSTAGE = NSTAGE_DEF,
    parameter int XLEN   = XLEN_DEF,
    parameter int PW     = PW_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [PW-1:0]            in_payload,
    input  logic [NSRC*REG_AW-1:0]   in_src_addr,
    input  logic [NSRC-1:0]          in_src_en,
    input  logic [REG_AW-1:0]        in_dest,
    input  logic                     in_dest_en,
    input  logic                     in_long,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PW-1:0]            out_payload,
    output logic [NSRC*XLEN-1:0]     out_src_data,
    output logic [NSRC*REG_AW-1:0]   rf_raddr,
    input  logic [NSRC*XLEN-1:0]     rf_rdata,
    input  logic [NSTAGE-1:0]        byp_valid,
    input  logic [NSTAGE*REG_AW-1:0] byp_dest,
    input  logic [NSTAGE-1:0]        byp_rdy,
    input  logic [NSTAGE*XLEN-1:0]   byp_data,
    input  logic                     ret_valid,
    input  logic [REG_AW-1:0]        ret_dest,
    input  logic                     flush,
    output logic                     sb_err
);

    localparam int NLOOK = NSRC + 1;
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    // Holding register
    logic                   held_valid_r;
    logic [PW-1:0]          held_payload_r;
    logic [NSRC*REG_AW-1:0] held_src_r;
    logic [NSRC-1:0]        held_src_en_r;
    logic [REG_AW-1:0]      held_dest_r;
    logic                   held_dest_en_r;
    logic                   held_long_r;

    // Operand resolution and hazard terms
    logic [NSTAGE-1:0]      hit_s       [NSRC];
    logic [NSTAGE-1:0]      first_s     [NSRC];
    logic [NSRC-1:0]        found_s;
    logic [NSRC-1:0]        match_rdy_s;
    logic [XLEN-1:0]        match_data_s[NSRC];
    logic [NSRC-1:0]        port_haz_s;
    logic [NSRC*XLEN-1:0]   src_data_s;
    logic                   sat_haz_s;
    logic                   hazard_s;
    logic                   fire_s;
    logic                   capture_s;
    logic                   sb_inc_s;
    logic                   sb_dec_s;
    logic [NLOOK*REG_AW-1:0] look_addr_s;
    logic [NLOOK*CNT_W-1:0]  look_cnt_s;
    logic [CNT_W-1:0]        dest_cnt_s;

    // Scoreboard lookups: all source ports plus the held destination
    assign look_addr_s = {held_dest_r, held_src_r};
    assign dest_cnt_s  = look_cnt_s[NSRC*CNT_W +: CNT_W];

    // Per-port bypass match, youngest stage first, then hazard and operand
    always_comb begin
        src_data_s = {(NSRC*XLEN){1'b0}};
        port_haz_s = {NSRC{1'b0}};
        for (int p = 0; p < NSRC; p++) begin
            for (int s = 0; s < NSTAGE; s++) begin
                hit_s[p][s] = byp_valid[s]
                           && (byp_dest[s*REG_AW +: REG_AW] == held_src_r[p*REG_AW +: REG_AW]);
            end
            first_s[p]      = first_hit(hit_s[p]);
            found_s[p]      = |hit_s[p];
            match_rdy_s[p]  = |(first_s[p] & byp_rdy);
            match_data_s[p] = {XLEN{1'b0}};
            for (int s = 0; s < NSTAGE; s++) begin
                match_data_s[p] = match_data_s[p]
                               | ({XLEN{first_s[p][s]}} & byp_data[s*XLEN +: XLEN]);
            end
            port_haz_s[p] = src_active(held_src_en_r[p], held_src_r[p*REG_AW +: REG_AW])
                         && ((found_s[p] && !match_rdy_s[p])
                             || (look_cnt_s[p*CNT_W +: CNT_W] != CNT_ZERO));
            src_data_s[p*XLEN +: XLEN] =
                (held_src_r[p*REG_AW +: REG_AW] == 5'd0) ? {XLEN{1'b0}} :
                found_s[p]                               ? match_data_s[p] :
                                                           rf_rdata[p*XLEN +: XLEN];
        end
    end

    // A fourth outstanding long write to one register would wrap its counter
    assign sat_haz_s = held_dest_en_r && (held_dest_r != 5'd0) && held_long_r
                    && (dest_cnt_s == CNT_MAX);

    assign hazard_s  = (|port_haz_s) || sat_haz_s;
    assign out_valid = held_valid_r && !hazard_s;
    assign fire_s    = out_valid && out_ready;
    assign in_ready  = !held_valid_r || fire_s;
    assign capture_s = in_valid && in_ready && !flush;

    assign sb_inc_s  = fire_s && held_dest_en_r && held_long_r && (held_dest_r != 5'd0);
    assign sb_dec_s  = ret_valid && (ret_dest != 5'd0);

    assign out_payload  = held_payload_r;
    assign out_src_data = src_data_s;
    assign rf_raddr     = held_src_r;

    // Holding register: flush wins over capture, capture refills after fire
    always_ff @(posedge clk) begin
        if (!resetn) begin
            held_valid_r   <= 1'b0;
            held_payload_r <= {PW{1'b0}};
            held_src_r     <= {(NSRC*REG_AW){1'b0}};
            held_src_en_r  <= {NSRC{1'b0}};
            held_dest_r    <= 5'd0;
            held_dest_en_r <= 1'b0;
            held_long_r    <= 1'b0;
        end else if (flush) begin
            held_valid_r   <= 1'b0;
        end else if (capture_s) begin
            held_valid_r   <= 1'b1;
            held_payload_r <= in_payload;
            held_src_r     <= in_src_addr;
            held_src_en_r  <= in_src_en;
            held_dest_r    <= in_dest;
            held_dest_en_r <= in_dest_en;
            held_long_r    <= in_long;
        end else if (fire_s) begin
            held_valid_r   <= 1'b0;
        end else begin
            held_valid_r   <= held_valid_r;
        end
    end

    id_scoreboard #(
        .CNT_W (CNT_W),
        .NLOOK (NLOOK)
    ) u_scoreboard (
        .clk       (clk),
        .resetn    (resetn),
        .inc_en    (sb_inc_s),
        .inc_addr  (held_dest_r),
        .dec_en    (sb_dec_s),
        .dec_addr  (ret_dest),
        .look_addr (look_addr_s),
        .look_cnt  (look_cnt_s),
        .err       (sb_err)
    );

endmodule

// File: doc/id_issue_unit.md
ID_ISSUE_UNIT -- requirements
Module: id_issue_unit

Interface
REQ-001 Parameters: NSRC=2 (source read ports); NSTAGE=3 (bypass stages, index 0 youngest); XLEN=32; PW=128 (payload width); CNT_W=2 (per-register pending-count width).
REQ-002 clk  in  1  clock; resetn  in  1  reset, synchronous, active-low.
REQ-003 in_valid  in  1; in_ready  out  1; in_payload  in  PW: decoded instruction from fetch side.
REQ-004 in_src_addr  in  NSRC*5; in_src_en  in  NSRC: per-port source register and use flag.
REQ-005 in_dest  in  5; in_dest_en  in  1; in_long  in  1 (dest produced by long-latency unit: load/div).
REQ-006 out_valid  out  1; out_ready  in  1; out_payload  out  PW; out_src_data  out  NSRC*XLEN (resolved operands).
REQ-007 rf_raddr  out  NSRC*5; rf_rdata  in  NSRC*XLEN: combinational regfile read of held entry.
REQ-008 byp_valid  in  NSTAGE; byp_dest  in  NSTAGE*5; byp_rdy  in  NSTAGE (data final); byp_data  in  NSTAGE*XLEN.
REQ-009 ret_valid  in  1; ret_dest  in  5: long-latency writeback retire.
REQ-010 flush  in  1: branch-cancel of held and incoming instruction.
REQ-011 sb_err  out  1: sticky scoreboard fault flag.

Function
REQ-012 One-entry holding register (held_valid + payload/src/dest fields); captures in_* when in_valid & in_ready & ~flush.
REQ-013 in_ready = ~held_valid | (out_valid & out_ready); no combinational path from in_valid to in_ready.
REQ-014 out_valid = held_valid & ~hazard; out_payload/out_src_data reflect held entry combinationally.
REQ-015 Per port p: active = in_src_en[p] & addr!=0; inactive port never hazards, data = 0 when addr==0.
REQ-016 Operand select: highest-priority (lowest index) stage with byp_valid & byp_dest==addr; if none, rf_rdata.
REQ-017 Hazard on active port if matched stage has byp_rdy=0, or sb_cnt[addr]!=0.
REQ-018 Hazard also if in_dest_en & dest!=0 & in_long & sb_cnt[dest]==2^CNT_W-1 (saturation stall).
REQ-019 Scoreboard: NREG=32 counters of CNT_W bits; increment on issue fire (out_valid & out_ready) with long dest!=0; decrement on ret_valid & ret_dest!=0.
REQ-020 Same-cycle increment and decrement of same register: count unchanged.
REQ-021 Decrement is registered: a source waiting on a long op issues no earlier than the cycle after ret_valid (value read from regfile).
REQ-022 ret_valid with count 0: counter stays 0, sb_err set, held until reset.
REQ-023 flush: held_valid<=0 next cycle; same-cycle in_valid is dropped; scoreboard unaffected (downstream ops already issued still retire).
REQ-024 flush with simultaneous issue fire: issue completes (counter increments), entry then cleared.
REQ-025 Held entry with hazard is stable: payload and addresses unchanged until fire or flush.

Reset
REQ-026 On resetn=0 at clk edge: held_valid=0, all sb_cnt=0, sb_err=0; thus out_valid=0, in_ready=1 first cycle after reset.
REQ-027 Reset mid-stall discards held entry; no retire is expected for pre-reset issues.

Structure
REQ-028 Shared package holds REG_AW=5, NREG=32, default XLEN/PW/CNT_W, and bypass-port field widths.
REQ-029 Scoreboard counters in sub-module id_scoreboard (inc/dec ports, count lookup per port, err output); select/hazard logic and holding register in top.

Verification
REQ-030 Back-to-back ALU: issue add r3; next instr reads r3 with byp stage0 valid/rdy data=0x1234 -> out_src_data=0x1234, no stall.
REQ-031 Load-use: stage0 dest r5 byp_rdy=0 for 1 cycle -> out_valid=0 one cycle, then operand from stage1 data=0xdead_beef.
REQ-032 Long op: issue div r7 (long); consumer of r7 stalls until ret_valid r7 at cycle N -> out_valid first at N+1, operand = rf_rdata.
REQ-033 Saturation: issue 3 long ops to r9 (CNT_W=2) -> 4th long write to r9 stalls until one retire.
REQ-034 Flush during stall with in_valid=1 -> next cycle held_valid=0, new payload not captured, sb counts unchanged.
REQ-035 Spurious ret_valid r2 with count 0 -> sb_err=1 persists; r0 source with any bypass match -> operand 0, no stall.
